rtype_exec_arbiter: RTL and testbench

- Shares the single-cycle R-type execute datapath (`dut`: `inst` in, `rd_val` out) between `N_REQ` instruction requesters.
- Per-requester valid/ready handshake; round-robin grant.
- Drives the granted instruction onto the datapath, waits out its latency and returns the captured `rd_val` as a tagged response.
- Sits between the per-hart fetch/issue stages and the shared execute datapath.

---
 rtl/rtype_pkg.sv | 44 ++++
 rtl/rtype_rr_pick.sv | 48 ++++
 rtl/rtype_exec_arbiter.sv | 165 ++++++++++++++++
 tb/tb_rtype_exec_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtype_pkg.sv
// -----------------------------------------------------------------------------
// rtype_pkg
// Shared constants, FSM state type and the R-type legality helper used by the
// R-type execute arbiter.
// Contents:
//   OP_RTYPE, NOP_INST, F7_BASE, F7_ALT  - instruction field constants
//   state_t                              - arbiter FSM states {IDLE, EXEC, RESP}
//   rtype_illegal()                      - legality of opcode/funct3/funct7
// -----------------------------------------------------------------------------
package rtype_pkg;

    localparam logic [6:0]  OP_RTYPE = 7'b0110011;
    localparam logic [31:0] NOP_INST = 32'h0000_0033;
    localparam logic [6:0]  F7_BASE  = 7'b0000000;
    localparam logic [6:0]  F7_ALT   = 7'b0100000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Takes only the decoded fields so callers pass exactly what is inspected.
    // F7_ALT is legal only for SUB (funct3 000) and SRA (funct3 101).
    function automatic logic rtype_illegal(
        input logic [6:0] opcode,
        input logic [2:0] funct3,
        input logic [6:0] funct7
    );
        logic bad;
        bad = 1'b0;
        if (opcode != OP_RTYPE) begin
            bad = 1'b1;
        end else if (funct7 == F7_BASE) begin
            bad = 1'b0;
        end else if (funct7 == F7_ALT) begin
            bad = !((funct3 == 3'b000) || (funct3 == 3'b101));
        end else begin
            bad = 1'b1;
        end
        return bad;
    endfunction

endpackage

// File: rtl/rtype_rr_pick.sv
// -----------------------------------------------------------------------------
// rtype_rr_pick
// Combinational round-robin winner: the first valid requester found scanning
// ptr, ptr+1, ... cyclically modulo N_REQ.
// Ports:
//   req_valid [N_REQ-1:0]          in  per-requester valid
//   ptr       [$clog2(N_REQ)-1:0]  in  round-robin start position (< N_REQ)
//   grant     [N_REQ-1:0]          out one-hot winner (all zero if none valid)
//   win_idx   [$clog2(N_REQ)-1:0]  out winner index (0 if none valid)
//   any_valid                      out at least one requester valid
// -----------------------------------------------------------------------------
module rtype_rr_pick #(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic [N_REQ-1:0]         grant,
    output logic [$clog2(N_REQ)-1:0] win_idx,
    output logic                     any_valid
);

    localparam int IW = $clog2(N_REQ);

    int          sum;
    logic [IW-1:0] idx;

    // Cyclic scan from ptr; the first valid hit wins, later hits are ignored.
    always_comb begin
        grant     = '0;
        win_idx   = '0;
        any_valid = 1'b0;
        sum       = 0;
        idx       = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = int'(ptr) + k;
            // ptr < N_REQ and k < N_REQ, so one subtraction wraps correctly.
            idx = (sum >= N_REQ) ? IW'(sum - N_REQ) : IW'(sum);
            if (!any_valid && req_valid[idx]) begin
                grant[idx] = 1'b1;
                win_idx    = idx;
                any_valid  = 1'b1;
            end else begin
                any_valid = any_valid;
            end
        end
    end

endmodule

// File: rtl/rtype_exec_arbiter.sv
// -----------------------------------------------------------------------------
// rtype_exec_arbiter
// Shares one R-type execute datapath between N_REQ requesters. A round-robin
// winner is accepted in IDLE, its instruction is held on dp_inst for DP_LAT+1
// cycles (EXEC), the datapath result is captured and returned as a tagged
// response (RESP) until the consumer accepts it. One transaction in flight.
// Optional feature macro: RTYPE_ARB_ILLEGAL_CHECK_EN -- when defined, illegal
// instructions bypass EXEC and return rsp_err=1, rsp_data=0.
// Ports:
//   clk, rst (sync, active-low)
//   req_valid[N_REQ], req_inst[32*N_REQ] in; req_ready[N_REQ] out
//   dp_inst[32] out, dp_rd_val[32] in      shared datapath
//   rsp_valid, rsp_id, rsp_data[32], rsp_err out; rsp_ready in
//   busy out                               FSM not in IDLE
// -----------------------------------------------------------------------------
module rtype_exec_arbiter
    import rtype_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int DP_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [32*N_REQ-1:0]      req_inst,
    output logic [N_REQ-1:0]         req_ready,
    output logic [31:0]              dp_inst,
    input  logic [31:0]              dp_rd_val,
    output logic                     rsp_valid,
    output logic [$clog2(N_REQ)-1:0] rsp_id,
    output logic [31:0]              rsp_data,
    output logic                     rsp_err,
    input  logic                     rsp_ready,
    output logic                     busy
);

    localparam int IW = $clog2(N_REQ);

    state_t          state, state_nxt;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   win_idx;
    logic [N_REQ-1:0] grant;
    logic            any_valid;
    logic            accept;
    logic            illegal;
    logic [31:0]     sel_inst;
    logic [2:0]      lat_cnt;

    rtype_rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req_valid (req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .win_idx   (win_idx),
        .any_valid (any_valid)
    );

    assign sel_inst = req_inst[int'(win_idx)*32 +: 32];

`ifdef RTYPE_ARB_ILLEGAL_CHECK_EN
    assign illegal = rtype_illegal(sel_inst[6:0], sel_inst[14:12], sel_inst[31:25]);
`else
    assign illegal = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and the requester-side handshake. req_ready is combinational
    // so a requester becoming valid in the IDLE cycle is taken on that edge.
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (rst) begin
                    req_ready = grant;
                    accept    = any_valid;
                end else begin
                    req_ready = '0;
                    accept    = 1'b0;
                end
                if (accept) begin
                    state_nxt = illegal ? RESP : EXEC;
                end else begin
                    state_nxt = IDLE;
                end
            end
            EXEC: begin
                if (lat_cnt == 3'd0) begin
                    state_nxt = RESP;
                end else begin
                    state_nxt = EXEC;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = RESP;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Pointer, latency counter, datapath drive and response registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr       <= '0;
            lat_cnt   <= 3'd0;
            dp_inst   <= NOP_INST;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= 32'd0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rsp_valid <= (state_nxt == RESP);
            busy      <= (state_nxt != IDLE);
            case (state)
                IDLE: begin
                    if (accept) begin
                        ptr     <= (win_idx == IW'(N_REQ - 1)) ? '0 : win_idx + IW'(1);
                        rsp_id  <= win_idx;
                        rsp_err <= illegal;
                        // Counts DP_LAT..0, giving DP_LAT+1 EXEC cycles.
                        lat_cnt <= 3'(DP_LAT);
                        if (illegal) begin
                            rsp_data <= 32'd0;
                            dp_inst  <= NOP_INST;
                        end else begin
                            dp_inst  <= sel_inst;
                        end
                    end else begin
                        dp_inst <= NOP_INST;
                    end
                end
                EXEC: begin
                    if (lat_cnt == 3'd0) begin
                        rsp_data <= dp_rd_val;
                        dp_inst  <= NOP_INST;
                    end else begin
                        lat_cnt  <= lat_cnt - 3'd1;
                    end
                end
                RESP: begin
                    dp_inst <= NOP_INST;
                end
                default: begin
                    dp_inst <= NOP_INST;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rtype_exec_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rtype_exec_arbiter
// Self-checking bench for rtype_exec_arbiter (N_REQ=3, DP_LAT=1). A
// transaction-level model (round-robin pointer, absolute response cycle) is
// compared against the DUT on every falling edge; directed sequences add
// literal expectations, then randomized traffic with random resets runs.
// -----------------------------------------------------------------------------
module tb_rtype_exec_arbiter;

    localparam int N      = 3;
    localparam int DP_LAT = 1;
    localparam logic [31:0] NOP = 32'h0000_0033;

    logic             clk;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [32*N-1:0]  req_inst;
    logic [N-1:0]     req_ready;
    logic [31:0]      dp_inst;
    logic [31:0]      dp_rd_val;
    logic             rsp_valid;
    logic [1:0]       rsp_id;
    logic [31:0]      rsp_data;
    logic             rsp_err;
    logic             rsp_ready;
    logic             busy;
    logic             stub = 1'b0;

    int checks = 0;
    int errors = 0;

    rtype_exec_arbiter #(.N_REQ(N), .DP_LAT(DP_LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_inst  (req_inst),
        .req_ready (req_ready),
        .dp_inst   (dp_inst),
        .dp_rd_val (dp_rd_val),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .rsp_ready (rsp_ready),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Arbitrary datapath function; stub mode returns 5.
    function automatic logic [31:0] dp_func(input logic [31:0] i);
        return {i[15:0], i[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    // One-register datapath stub (DP_LAT = 1).
    always @(posedge clk) dp_rd_val <= stub ? 32'd5 : dp_func(dp_inst);

    // ---------------- behavioural model ----------------
    int          cyc       = 0;
    bit          m_busy    = 1'b0;
    int          m_ptr     = 0;
    int          m_id      = 0;
    logic [31:0] m_inst    = 32'd0;
    logic [31:0] m_data    = 32'd0;
    bit          m_err     = 1'b0;
    int          m_resp_at = 0;

    function automatic bit model_illegal(input logic [31:0] i);
`ifdef RTYPE_ARB_ILLEGAL_CHECK_EN
        bit legal;
        legal = (i[6:0] == 7'h33) &&
                ((i[31:25] == 7'h00) ||
                 ((i[31:25] == 7'h20) && ((i[14:12] == 3'd0) || (i[14:12] == 3'd5))));
        return !legal;
`else
        return (i == 32'hFFFF_FFFF) && (i != 32'hFFFF_FFFF);
`endif
    endfunction

    function automatic int win();
        for (int k = 0; k < N; k++)
            if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    function automatic logic [31:0] win_inst();
        return req_inst[win()*32 +: 32];
    endfunction

    function automatic logic [N-1:0] exp_ready();
        logic [N-1:0] r;
        r = '0;
        if (rst && !m_busy && win() >= 0) r[win()] = 1'b1;
        return r;
    endfunction

    // Model update on each rising edge from the inputs present before it.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst) begin
            m_busy <= 1'b0;
            m_ptr  <= 0;
        end else if (!m_busy) begin
            if (win() >= 0) begin
                m_busy    <= 1'b1;
                m_ptr     <= (win() + 1) % N;
                m_id      <= win();
                m_inst    <= win_inst();
                m_err     <= model_illegal(win_inst());
                m_data    <= model_illegal(win_inst()) ? 32'd0 :
                             (stub ? 32'd5 : dp_func(win_inst()));
                m_resp_at <= cyc + 1 + (model_illegal(win_inst()) ? 0 : DP_LAT + 1);
            end
        end else if (cyc >= m_resp_at && rsp_ready) begin
            m_busy <= 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("busy",      32'(busy),      32'(m_busy));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_busy && cyc >= m_resp_at));
        chk("dp_inst",   dp_inst, (m_busy && cyc < m_resp_at) ? m_inst : NOP);
        chk("req_ready", 32'(req_ready), 32'(exp_ready()));
        if (m_busy && cyc >= m_resp_at) begin
            chk("rsp_id",   32'(rsp_id),  32'(m_id));
            chk("rsp_data", rsp_data,     m_data);
            chk("rsp_err",  32'(rsp_err), 32'(m_err));
        end
    end

    task automatic wait_rsp(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL wait_rsp: rsp_valid low for %0d cycles", budget);
        end
    endtask

    task automatic wait_idle(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (busy === 1'b0) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: busy high for %0d cycles", budget);
        end
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 4))
            0, 1:    return {7'b0000000, r[24:12], r[11:7], 7'b0110011};
            2:       return {7'b0100000, r[24:15], (r[0] ? 3'b101 : 3'b000), r[11:7], 7'b0110011};
            3:       return {7'b0100000, r[24:12], r[11:7], 7'b0110011};
            default: return r;
        endcase
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b0;
        req_valid = '1;
        req_inst  = '0;
        rsp_ready = 1'b0;

        // 1. Reset with all requesters valid.
        repeat (2) @(negedge clk);
        chk("t1_req_ready", 32'(req_ready), 32'd0);
        chk("t1_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("t1_dp_inst",   dp_inst,        32'h0000_0033);
        chk("t1_busy",      32'(busy),      32'd0);
        chk("t1_rsp_id",    32'(rsp_id),    32'd0);
        chk("t1_rsp_data",  rsp_data,       32'd0);
        chk("t1_rsp_err",   32'(rsp_err),   32'd0);
        #1 rst = 1'b1; req_valid = '0; stub = 1'b1;

        // 2. Single request, stub datapath returns 5.
        @(negedge clk); #1 req_valid = 3'b001; req_inst[31:0] = 32'h0020_8333;
        @(negedge clk);
        chk("t2_dp_inst_a", dp_inst, 32'h0020_8333);
        chk("t2_busy", 32'(busy), 32'd1);
        #1 req_valid = '0;
        @(negedge clk);
        chk("t2_dp_inst_b", dp_inst, 32'h0020_8333);
        chk("t2_rsp_early", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("t2_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("t2_rsp_id",    32'(rsp_id),    32'd0);
        chk("t2_rsp_data",  rsp_data,       32'd5);
        chk("t2_rsp_err",   32'(rsp_err),   32'd0);
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        chk("t2_rsp_done",  32'(rsp_valid), 32'd0);
        chk("t2_dp_nop",    dp_inst,        NOP);
        #1 stub = 1'b0; rst = 1'b0;

        // 3. Fairness: requesters 0 and 1 continuously valid.
        @(negedge clk);
        #1 rst = 1'b1; req_valid = 3'b011;
        req_inst[31:0]  = 32'h4020_8333;
        req_inst[63:32] = 32'h0031_01B3;
        for (int k = 0; k < 4; k++) begin
            wait_rsp(20);
            chk("t3_rsp_id", 32'(rsp_id), 32'(k % 2));
        end
        #1 rsp_ready = 1'b0;

        // 4. Backpressure on the held response from requester 1.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t4_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("t4_rsp_id",    32'(rsp_id),    32'd1);
            chk("t4_rsp_data",  rsp_data,       dp_func(32'h0031_01B3));
            chk("t4_req_ready", 32'(req_ready), 32'd0);
        end
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        chk("t4_released",   32'(rsp_valid), 32'd0);
        chk("t4_ready_next", 32'(req_ready), 32'b001);
        @(negedge clk);
        chk("t4_accepted",   32'(busy),      32'd1);
        #1 req_valid = '0;
        wait_idle(20);

        // 5. ADDI is illegal only with the check enabled.
        #1 req_valid = 3'b001; req_inst[31:0] = 32'h0010_0093; rsp_ready = 1'b0;
        @(negedge clk);
`ifdef RTYPE_ARB_ILLEGAL_CHECK_EN
        chk("t5_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("t5_rsp_err",   32'(rsp_err),   32'd1);
        chk("t5_rsp_data",  rsp_data,       32'd0);
        chk("t5_dp_nop",    dp_inst,        NOP);
        #1 req_valid = '0;
`else
        chk("t5_dp_inst",   dp_inst,        32'h0010_0093);
        chk("t5_rsp_early", 32'(rsp_valid), 32'd0);
        #1 req_valid = '0;
        wait_rsp(10);
        chk("t5_rsp_err",   32'(rsp_err),   32'd0);
        chk("t5_rsp_data",  rsp_data,       dp_func(32'h0010_0093));
`endif
        #1 rsp_ready = 1'b1;
        wait_idle(20);

        // 6. Reset during EXEC, then requester 1 served normally.
        #1 req_valid = 3'b001; req_inst[31:0] = 32'h0000_0533;
        @(negedge clk);
        chk("t6_exec", 32'(busy), 32'd1);
        #1 rst = 1'b0; req_valid = '0;
        @(negedge clk);
        chk("t6_busy",      32'(busy),      32'd0);
        chk("t6_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("t6_dp_nop",    dp_inst,        NOP);
        chk("t6_req_ready", 32'(req_ready), 32'd0);
        #1 rst = 1'b1; req_valid = 3'b011;
        #1 chk("t6_ptr_zero", 32'(req_ready), 32'b001);
        #1 req_valid = 3'b010; req_inst[63:32] = 32'h4041_D2B3;
        @(negedge clk);
        chk("t6_dp_inst", dp_inst, 32'h4041_D2B3);
        #1 req_valid = '0;
        wait_rsp(10);
        chk("t6_rsp_id",   32'(rsp_id), 32'd1);
        chk("t6_rsp_data", rsp_data,    dp_func(32'h4041_D2B3));
        wait_idle(20);

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    req_valid[i] = 1'($urandom_range(0, 1));
                    req_inst[i*32 +: 32] = rand_inst();
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 299) != 0);
        end
        @(negedge clk);
        #1 rst = 1'b1; req_valid = '0; rsp_ready = 1'b1;
        wait_idle(20);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
